muldiv_ctrl: RTL and testbench

//  Sequences the multi-cycle HI/LO multiply/divide unit beside the EXE stage: accepts MULT/MULTU/DIV/DIVU,

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_iter_core.sv | 27 ++
 rtl/muldiv_ctrl.sv | 149 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op codes, FSM encoding and constants for the HI/LO multiply/divide unit
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_t;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - one shift-add (multiply) or restoring shift-subtract (divide) step
module muldiv_iter_core (
  input  logic        is_div,
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  output logic [63:0] acc_next
);

  logic [32:0] add_sum;
  logic [32:0] sub_diff;

  // Multiply: acc = {partial product, remaining multiplier bits}; divide: acc = {remainder, dividend/quotient}.
  assign add_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign sub_diff = acc[63:31] - {1'b0, opnd};

  always_comb begin
    acc_next = {add_sum, acc[31:1]};
    if (is_div) begin
      if (!sub_diff[32]) begin
        acc_next = {sub_diff[31:0], acc[30:0], 1'b1};
      end else begin
        acc_next = {acc[62:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO multiply/divide sequencer with MTHI/MTLO path
// MULDIV_FAST_MUL_EN: single-cycle combinational MULT/MULTU; divide stays iterative.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int ITER  = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      acc;
  logic [63:0]      acc_next;
  logic [31:0]      opnd;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic             div0;

  logic             is_signed_op;
  logic             op_is_div;
  logic             a_neg;
  logic             b_neg;
  logic [31:0]      mag_a;
  logic [31:0]      mag_b;
  logic [31:0]      quo;
  logic [31:0]      rem;

  always_comb begin
    is_signed_op = (op_code == OP_MULT) || (op_code == OP_DIV);
    op_is_div    = (op_code == OP_DIV) || (op_code == OP_DIVU);
    a_neg        = is_signed_op & op_a[31];
    b_neg        = is_signed_op & op_b[31];
    mag_a        = a_neg ? -op_a : op_a;
    mag_b        = b_neg ? -op_b : op_b;
  end

  assign quo = acc[31:0];
  assign rem = acc[63:32];

`ifdef MULDIV_FAST_MUL_EN
  logic signed [63:0] sprod;
  logic [63:0]        uprod;
  assign sprod = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
  assign uprod = {32'd0, op_a} * {32'd0, op_b};
`endif

  muldiv_iter_core u_core (
    .is_div   (is_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (op_valid) begin
`ifdef MULDIV_FAST_MUL_EN
              if (!op_is_div) begin
                {hi, lo} <= is_signed_op ? sprod : uprod;
                done     <= 1'b1;
              end else
`endif
              begin
                state   <= S_RUN;
                busy    <= 1'b1;
                cnt     <= '0;
                is_div  <= op_is_div;
                neg_res <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                div0    <= op_is_div && (op_b == 32'd0);
                acc     <= op_is_div ? {32'd0, mag_a} : {32'd0, mag_b};
                opnd    <= op_is_div ? mag_b : mag_a;
              end
            end else begin
              if (hi_we) hi <= wdata;
              if (lo_we) lo <= wdata;
            end
          end
          S_RUN: begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= S_FIX;
          end
          S_FIX: begin
            // Divide-by-zero leaves the dividend in the remainder, so only LO needs overriding.
            if (is_div) begin
              lo <= div0 ? DIV0_LO : (neg_res ? -quo : quo);
              hi <= neg_rem ? -rem : rem;
            end else begin
              {hi, lo} <= neg_res ? -acc : acc;
            end
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  a_no_req_while_busy: assert property (@(posedge clk) disable iff (rst)
    busy |-> !(op_valid || hi_we || lo_we))
    else $warning("muldiv_ctrl: request ignored while busy");

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'b00;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc;
  int busy_cnt;
  int done_cnt;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge of cycle 1 (cycle 0 is the accept cycle).
  task automatic issue(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = code;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_done;
    busy_cnt = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int lat);
    issue(code, a, b);
    cyc = 1;
    wait_done();
    check({tag, "_lat"}, 64'(cyc), 64'(lat));
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;

    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);
    check("divu_busy_cycles", 64'(busy_cnt), 64'd33);
    check("divu_busy_low_at_done", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("divu_done_one_cycle", {63'd0, done}, 64'd0);

    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT);
    run_op("divu_by0", 2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, DIV_LAT);
    run_op("div_by0_neg", 2'b10, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, DIV_LAT);

    run_op("mult_m3_5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT);
    check("mult_busy_cycles", 64'(busy_cnt), 64'(MUL_LAT - 1));
    run_op("multu_big", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
    run_op("mult_neg_neg", 2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'd0, 32'd42, MUL_LAT);

    // flush in cycle 10 of a DIV; HI/LO keep 0/42 from the previous op
    issue(2'b10, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(done_cnt), 64'd0);
    check("flush_hi_kept", {32'd0, hi}, 64'd0);
    check("flush_lo_kept", {32'd0, lo}, 64'd42);

    // flush together with op_valid in IDLE: op not accepted
    op_valid = 1'b1;
    op_code  = 2'b11;
    op_a     = 32'd9;
    op_b     = 32'd3;
    flush    = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    flush    = 1'b0;
    check("flush_accept_busy", {63'd0, busy}, 64'd0);
    check("flush_accept_done", {63'd0, done}, 64'd0);

    // reset in cycle 10 of a DIVU
    issue(2'b11, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_busy", {63'd0, busy}, 64'd0);
    check("rstmid_hi", {32'd0, hi}, 64'd0);
    check("rstmid_lo", {32'd0, lo}, 64'd0);

    // MTLO / MTHI in IDLE
    lo_we = 1'b1;
    wdata = 32'h0000_CAFE;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", {32'd0, lo}, 64'h0000_CAFE);
    check("mtlo_busy", {63'd0, busy}, 64'd0);
    check("mtlo_done", {63'd0, done}, 64'd0);
    hi_we = 1'b1;
    wdata = 32'h0000_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", {32'd0, hi}, 64'h0000_BEEF);
    check("mthi_lo_kept", {32'd0, lo}, 64'h0000_CAFE);

    // lo_we in cycle 5 of a busy op is dropped
`ifdef MULDIV_FAST_MUL_EN
    issue(2'b11, 32'd100, 32'd7);
`else
    issue(2'b01, 32'h0001_0000, 32'h0003_0003);
`endif
    cyc = 1;
    repeat (4) @(negedge clk);
    cyc = 5;
    lo_we = 1'b1;
    wdata = 32'h0000_5555;
    @(negedge clk);
    lo_we = 1'b0;
    cyc = 6;
    wait_done();
    check("busy_we_done", {63'd0, done}, 64'd1);
`ifdef MULDIV_FAST_MUL_EN
    check("busy_we_hi", {32'd0, hi}, 64'd2);
    check("busy_we_lo", {32'd0, lo}, 64'd14);
`else
    check("busy_we_hi", {32'd0, hi}, 64'd3);
    check("busy_we_lo", {32'd0, lo}, 64'h0003_0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
